outer_in_fifo_adapter: RTL

Parametrised successor of the outer-input adapter. Sits between the off-chip input stream (`o__in`) and a hub input port (`h__in`) and adds a DEPTH-entry registered FIFO, configurable word width, and a transfer-word counter. One command opens one transfer, in one of two modes:
- Counted mode: size != 0 words.
- Automatic mode: size == 0; the transfer ends when the hub signals the last word.

---
 rtl/outer_in_fifo_adapter.sv | 75 +++++++
 1 files changed

// File: rtl/outer_in_fifo_adapter.sv
// outer_in_fifo_adapter: command-driven FIFO bridge from the outer input stream to a hub input port
module outer_in_fifo_adapter #(
    parameter int W = 64,
    parameter int LEN_BITS = 15,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_BITS-1:0] cmd,
    input  logic                cmd_isReady,
    output logic                cmd_canReceive,
    input  logic [W-1:0]        o__in,
    input  logic                o__in_isReady,
    output logic                o__in_canReceive,
    output logic [W-1:0]        h__in,
    output logic                h__in_isReady,
    input  logic                h__in_canReceive,
    output logic                h__in_isLast_in,
    input  logic                h__in_isLast_out,
    output logic [LEN_BITS-1:0] count,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN_CNT, RUN_AUTO} state_t;
    state_t state, stateNext;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0] occ;
    logic [LEN_BITS-1:0] size;
    logic [LEN_BITS:0] pending;
    logic run, limit, push, pop, cmdAcc;
    always_comb begin
        run = state != IDLE;
        pending = {1'b0, count} + (LEN_BITS + 1)'(occ);
        limit = state == RUN_AUTO || pending < {1'b0, size};
        cmd_canReceive = !run;
        busy = run;
        // occ[AW] is set only when the FIFO holds exactly DEPTH words
        o__in_canReceive = run && !occ[AW] && limit;
        h__in_isReady = run && occ != '0;
        h__in = h__in_isReady ? mem[rdPtr] : '0;
        h__in_isLast_in = state == RUN_CNT && h__in_isReady && count == size - LEN_BITS'(1);
        cmdAcc = cmd_isReady && cmd_canReceive;
        push = o__in_isReady && o__in_canReceive;
        pop = h__in_isReady && h__in_canReceive;
        stateNext = state;
        if (state == IDLE && cmdAcc)
            stateNext = cmd != '0 ? RUN_CNT : RUN_AUTO;
        else if (pop && (h__in_isLast_in || (state == RUN_AUTO && h__in_isLast_out)))
            stateNext = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rdPtr <= '0;
            wrPtr <= '0;
            occ <= '0;
            size <= '0;
            count <= '0;
        end else begin
            state <= stateNext;
            wrPtr <= wrPtr + AW'(push);
            rdPtr <= rdPtr + AW'(pop);
            occ <= occ + (AW + 1)'(push) - (AW + 1)'(pop);
            if (cmdAcc) begin
                size <= cmd;
                count <= '0;
            end else if (pop) begin
                count <= count + LEN_BITS'(1);
            end
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= o__in;
endmodule
